ir_queue: RTL and testbench

- Parametrised successor to the single-register instruction register.
- Holds up to DEPTH fetched instruction words in a circular queue so fetch can run ahead of decode.
- Presents the head instruction on a registered output, with its opcode field broken out for the control store.
- Sits between memory-data return and the LC-3b decode/control logic.

---
 rtl/ir_queue.sv | 156 +++++++++++++++
 tb/tb_ir_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// ir_queue: circular instruction queue feeding LC-3b decode.
// Fetch can run up to DEPTH words ahead of decode. The head word is held on
// a registered output, and its opcode field is broken out for the control store.
// Optional feature macro: IR_FLUSH_EN adds a flush input that empties the
// queue on a taken branch.
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             advance,
`ifdef IR_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] out,
  output logic [3:0]       opcode,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] out_r;
  logic             valid_r;
  logic             overflow_r;

  logic             empty_s;
  logic             full_s;
  logic             load_ok_s;
  logic             adv_ok_s;
  logic             drop_s;
  logic [AW-1:0]    rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] out_next_s;
  logic             valid_next_s;

  // Status flags come straight from the count register.
  always_comb begin
    empty_s = (count_r == CW'(0));
    full_s  = (count_r == CW'(DEPTH));
  end

  // Accept/drop decisions. A flush discards the same-cycle load and advance.
  always_comb begin
`ifdef IR_FLUSH_EN
    load_ok_s = load & (~full_s | advance) & ~flush;
    adv_ok_s  = advance & ~empty_s & ~flush;
    drop_s    = load & full_s & ~advance & ~flush;
`else
    load_ok_s = load & (~full_s | advance);
    adv_ok_s  = advance & ~empty_s;
    drop_s    = load & full_s & ~advance;
`endif
    rd_next_s = rd_ptr_r + AW'(1);
  end

  // The occupancy change is +1 for an accepted load and -1 for an accepted advance.
  always_comb begin
    count_next_s = count_r;
    case ({load_ok_s, adv_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      2'b11:   count_next_s = count_r;
      2'b00:   count_next_s = count_r;
      default: count_next_s = count_r;
    endcase
  end

  // Next head word. When the queue is empty, an incoming word bypasses to the head.
  // When the head retires, the entry behind it is promoted.
  always_comb begin
    out_next_s   = out_r;
    valid_next_s = valid_r;
    if (adv_ok_s) begin
      if (count_r == CW'(1)) begin
        if (load_ok_s) begin
          out_next_s   = in;
          valid_next_s = 1'b1;
        end else begin
          out_next_s   = out_r;
          valid_next_s = 1'b0;
        end
      end else begin
        out_next_s   = mem_r[rd_next_s];
        valid_next_s = 1'b1;
      end
    end else if (load_ok_s && empty_s) begin
      out_next_s   = in;
      valid_next_s = 1'b1;
    end else begin
      out_next_s   = out_r;
      valid_next_s = valid_r;
    end
  end

  // Entry storage. It has no reset because its contents are unused until written.
  always_ff @(posedge clock_50) begin
    if (load_ok_s) begin
      mem_r[wr_ptr_r] <= in;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy, head register and sticky overflow flag.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      out_r      <= WIDTH'(0);
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
`ifdef IR_FLUSH_EN
    end else if (flush) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      count_r    <= CW'(0);
      valid_r    <= 1'b0;
`endif
    end else begin
      if (load_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (adv_ok_s) begin
        rd_ptr_r <= rd_next_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_next_s;
      out_r   <= out_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign out      = out_r;
  assign opcode   = out_r[WIDTH-1 -: 4];
  assign valid    = valid_r;
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed bench for ir_queue. A queue-based reference model
// predicts every output and is compared on each falling edge. Literal checks
// at the key points of each scenario pin the model itself.
module tb_ir_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock_50 = 1'b0;
  logic             reset    = 1'b1;
  logic [WIDTH-1:0] din      = '0;
  logic             load     = 1'b0;
  logic             advance  = 1'b0;
  logic             flush    = 1'b0;
  logic [WIDTH-1:0] out;
  logic [3:0]       opcode;
  logic             valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_out   = '0;
  logic             m_valid = 1'b0;
  logic             m_ovf   = 1'b0;

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .in       (din),
    .load     (load),
    .advance  (advance),
`ifdef IR_FLUSH_EN
    .flush    (flush),
`endif
    .out      (out),
    .opcode   (opcode),
    .valid    (valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock_50 = ~clock_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Queue semantics: retire the front, append the new word, and the head is the front.
  task automatic model_step();
    bit lok;
    bit aok;
`ifdef IR_FLUSH_EN
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
`endif
    lok = load && ((mq.size() < DEPTH) || advance);
    aok = advance && (mq.size() > 0);
    if (load && !lok) m_ovf = 1'b1;
    if (aok) void'(mq.pop_front());
    if (lok) mq.push_back(din);
    if (mq.size() > 0) begin
      m_out   = mq[0];
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle: inputs are set off-edge, and the model advances right after the edge.
  task automatic step(input logic ld, input logic adv, input logic [WIDTH-1:0] d);
    load    = ld;
    advance = adv;
    din     = d;
    @(posedge clock_50);
    model_step();
    #1;
    load    = 1'b0;
    advance = 1'b0;
    flush   = 1'b0;
  endtask

  // Every-cycle comparison of DUT against model
  always @(negedge clock_50) begin
    if (checking) begin
      chk("m_out",      32'(out),      32'(m_out));
      chk("m_opcode",   32'(opcode),   32'(m_out[WIDTH-1 -: 4]));
      chk("m_valid",    32'(valid),    32'(m_valid));
      chk("m_count",    32'(count),    32'(mq.size()));
      chk("m_empty",    32'(empty),    32'(mq.size() == 0));
      chk("m_full",     32'(full),     32'(mq.size() == DEPTH));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  initial begin
    model_reset();
    checking = 1'b1;
    #3;
    chk("rst_out",   32'(out),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    #9 reset = 1'b0;
    @(posedge clock_50); #1;

    // 1: single load
    step(1'b1, 1'b0, 16'h1234);
    chk("t1_out",    32'(out),    32'h1234);
    chk("t1_opcode", 32'(opcode), 32'h1);
    chk("t1_valid",  32'(valid),  32'h1);
    chk("t1_count",  32'(count),  32'h1);
    chk("t1_empty",  32'(empty),  32'h0);
    step(1'b0, 1'b1, 16'h0);
    chk("t1_drain",  32'(count),  32'h0);

    // 2: fill, overflow, drain
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i));
    chk("t2_full",  32'(full),  32'h1);
    chk("t2_count", 32'(count), 32'h4);
    step(1'b1, 1'b0, 16'hA005);
    chk("t2_ovf",   32'(overflow), 32'h1);
    chk("t2_cnt5",  32'(count),    32'h4);
    chk("t2_head0", 32'(out),      32'hA001);
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("t2_head", 32'(out), 32'(16'hA000 + 16'(i)));
    end
    step(1'b0, 1'b1, 16'h0);
    chk("t2_valid0", 32'(valid), 32'h0);
    chk("t2_hold",   32'(out),   32'hA004);

    // 3: load+advance while full, pointer wrap
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'hB000 + 16'(i));
    step(1'b1, 1'b1, 16'hB000);
    chk("t3_count", 32'(count),    32'h4);
    chk("t3_ovf",   32'(overflow), 32'h1);
    chk("t3_head",  32'(out),      32'hB002);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    chk("t3_last",  32'(out),   32'hB000);
    chk("t3_cnt1",  32'(count), 32'h1);
    step(1'b0, 1'b1, 16'h0);
    chk("t3_empty", 32'(empty), 32'h1);

    // 4: count==1 with load+advance
    step(1'b1, 1'b0, 16'h2222);
    chk("t4_pre", 32'(out), 32'h2222);
    step(1'b1, 1'b1, 16'h3333);
    chk("t4_out",   32'(out),   32'h3333);
    chk("t4_valid", 32'(valid), 32'h1);
    chk("t4_count", 32'(count), 32'h1);
    step(1'b0, 1'b1, 16'h0);

    // 5: asynchronous reset mid-cycle
    step(1'b1, 1'b0, 16'hC001);
    step(1'b1, 1'b0, 16'hC002);
    step(1'b1, 1'b0, 16'hC003);
    chk("t5_pre", 32'(count), 32'h3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_out",   32'(out),      32'h0);
    chk("t5_valid", 32'(valid),    32'h0);
    chk("t5_count", 32'(count),    32'h0);
    chk("t5_ovf",   32'(overflow), 32'h0);
    reset = 1'b0;
    @(posedge clock_50); #1;
    step(1'b0, 1'b1, 16'h0);
    chk("t5_adv_empty_cnt", 32'(count), 32'h0);
    chk("t5_adv_empty_val", 32'(valid), 32'h0);
    chk("t5_adv_empty_out", 32'(out),   32'h0);

`ifdef IR_FLUSH_EN
    // 6: flush wins over load
    step(1'b1, 1'b0, 16'h6001);
    step(1'b1, 1'b0, 16'h6002);
    step(1'b1, 1'b0, 16'h6003);
    flush = 1'b1;
    step(1'b1, 1'b0, 16'h4444);
    chk("t6_count", 32'(count),    32'h0);
    chk("t6_valid", 32'(valid),    32'h0);
    chk("t6_out",   32'(out),      32'h6001);
    chk("t6_ovf",   32'(overflow), 32'h0);
    step(1'b1, 1'b0, 16'h5555);
    chk("t6_load",  32'(out),      32'h5555);
`endif

    @(negedge clock_50);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
